exm: RTL and testbench

- Execute stage of the ECAP5-DPROC pipeline.
- Sits directly downstream of the decode stage and consumes its execute, write-back and load-store bundle.
- Computes the ALU result, resolves branches and jumps, and redirects fetch.
- Presents one registered bundle to the load-store stage through a valid/ready handshake, and squashes wrong-path instructions after a taken branch.

---
 rtl/exm.sv | 193 +++++++++++++++++++
 tb/tb_exm.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exm.sv
// Execute stage of the ECAP5-DPROC pipeline.
// Computes the ALU result and resolves branches. It hands one registered
// bundle to the load-store stage and squashes wrong-path bundles after a
// taken branch until the bundle at the branch target arrives.

package exm_pkg;
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SLT   = 3'd1;
  localparam logic [2:0] ALU_SLTU  = 3'd2;
  localparam logic [2:0] ALU_XOR   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_AND   = 3'd5;
  localparam logic [2:0] ALU_SHIFT = 3'd6;

  localparam logic [2:0] NO_BRANCH     = 3'd0;
  localparam logic [2:0] BRANCH_BEQ    = 3'd1;
  localparam logic [2:0] BRANCH_BNE    = 3'd2;
  localparam logic [2:0] BRANCH_BLT    = 3'd3;
  localparam logic [2:0] BRANCH_BGE    = 3'd4;
  localparam logic [2:0] BRANCH_BLTU   = 3'd5;
  localparam logic [2:0] BRANCH_BGEU   = 3'd6;
  localparam logic [2:0] BRANCH_UNCOND = 3'd7;
endpackage

// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. The producer holds its bundle stable while
// valid is high and ready is low. input_ready_o is also high for a bundle
// that will be dropped while the stage is discarding wrong-path bundles.
module exm
  import exm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        input_ready_o,
  input  logic        input_valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] alu_operand1_i,
  input  logic [31:0] alu_operand2_i,
  input  logic [2:0]  alu_op_i,
  input  logic        alu_sub_i,
  input  logic        alu_shift_left_i,
  input  logic        alu_signed_shift_i,
  input  logic [2:0]  branch_cond_i,
  input  logic [19:0] branch_offset_i,
  input  logic        reg_write_i,
  input  logic [4:0]  reg_addr_i,
  input  logic        ls_enable_i,
  input  logic        ls_write_i,
  input  logic [31:0] ls_write_data_i,
  input  logic [3:0]  ls_sel_i,
  input  logic        ls_unsigned_load_i,
  input  logic        output_ready_i,
  output logic        output_valid_o,
  output logic [31:0] result_o,
  output logic        reg_write_o,
  output logic [4:0]  reg_addr_o,
  output logic        ls_enable_o,
  output logic        ls_write_o,
  output logic [31:0] ls_write_data_o,
  output logic [3:0]  ls_sel_o,
  output logic        ls_unsigned_load_o,
  output logic        branch_o,
  output logic [31:0] branch_target_o
);

  typedef enum logic {RUN, DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] discard_pc_q;

  logic        normal_ready;
  logic        drop;
  logic        fire;
  logic        process_bundle;
  logic [31:0] alu_result;
  logic [31:0] bundle_result;
  logic [31:0] target;
  logic        taken;
  logic        op_eq, op_lt_s, op_lt_u;

  // Handshake: dropped bundles are always swallowed; kept bundles wait for room.
  always_comb begin
    normal_ready   = !output_valid_o || output_ready_i;
    drop           = (state_q == DISCARD) && (pc_i != discard_pc_q);
    input_ready_o  = normal_ready || drop;
    fire           = input_valid_i && input_ready_o;
    process_bundle = fire && !drop;
  end

  // ALU: all arithmetic wraps modulo 2^32.
  always_comb begin
    alu_result = 32'h0;
    case (alu_op_i)
      ALU_ADD:  alu_result = alu_sub_i ? (alu_operand1_i - alu_operand2_i)
                                       : (alu_operand1_i + alu_operand2_i);
      ALU_SLT:  alu_result = {31'h0, $signed(alu_operand1_i) < $signed(alu_operand2_i)};
      ALU_SLTU: alu_result = {31'h0, alu_operand1_i < alu_operand2_i};
      ALU_XOR:  alu_result = alu_operand1_i ^ alu_operand2_i;
      ALU_OR:   alu_result = alu_operand1_i | alu_operand2_i;
      ALU_AND:  alu_result = alu_operand1_i & alu_operand2_i;
      ALU_SHIFT: begin
        if (alu_shift_left_i)
          alu_result = alu_operand1_i << alu_operand2_i[4:0];
        else if (alu_signed_shift_i)
          alu_result = $signed(alu_operand1_i) >>> alu_operand2_i[4:0];
        else
          alu_result = alu_operand1_i >> alu_operand2_i[4:0];
      end
      default:  alu_result = 32'h0;
    endcase
  end

  // Branch resolution: decide taken, the redirect target and the bundle result.
  always_comb begin
    op_eq   = alu_operand1_i == alu_operand2_i;
    op_lt_s = $signed(alu_operand1_i) < $signed(alu_operand2_i);
    op_lt_u = alu_operand1_i < alu_operand2_i;
    taken   = 1'b0;
    case (branch_cond_i)
      BRANCH_BEQ:    taken = op_eq;
      BRANCH_BNE:    taken = !op_eq;
      BRANCH_BLT:    taken = op_lt_s;
      BRANCH_BGE:    taken = !op_lt_s;
      BRANCH_BLTU:   taken = op_lt_u;
      BRANCH_BGEU:   taken = !op_lt_u;
      BRANCH_UNCOND: taken = 1'b1;
      default:       taken = 1'b0;
    endcase
    if (branch_cond_i == BRANCH_UNCOND) begin
      target        = (alu_operand1_i + alu_operand2_i) & ~32'h1;
      bundle_result = pc_i + 32'd4;
    end else begin
      target        = pc_i + {{12{branch_offset_i[19]}}, branch_offset_i};
      bundle_result = alu_result;
    end
  end

  // Next state: any processed bundle leaves DISCARD; a taken one (re)enters it.
  always_comb begin
    state_d = state_q;
    if (process_bundle)
      state_d = taken ? DISCARD : RUN;
  end

  // State register and the latched pc the discard comparator waits for.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= RUN;
      discard_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (process_bundle && taken)
        discard_pc_q <= target;
    end
  end

  // Output bundle register and the one-cycle redirect pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      output_valid_o     <= 1'b0;
      result_o           <= 32'h0;
      reg_write_o        <= 1'b0;
      reg_addr_o         <= 5'h0;
      ls_enable_o        <= 1'b0;
      ls_write_o         <= 1'b0;
      ls_write_data_o    <= 32'h0;
      ls_sel_o           <= 4'h0;
      ls_unsigned_load_o <= 1'b0;
      branch_o           <= 1'b0;
      branch_target_o    <= 32'h0;
    end else begin
      branch_o <= process_bundle && taken;
      if (process_bundle && taken)
        branch_target_o <= target;
      if (process_bundle) begin
        output_valid_o     <= 1'b1;
        result_o           <= bundle_result;
        reg_write_o        <= reg_write_i;
        reg_addr_o         <= reg_addr_i;
        ls_enable_o        <= ls_enable_i;
        ls_write_o         <= ls_write_i;
        ls_write_data_o    <= ls_write_data_i;
        ls_sel_o           <= ls_sel_i;
        ls_unsigned_load_o <= ls_unsigned_load_i;
      end else if (output_ready_i) begin
        output_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exm.sv
// Directed bench for the execute stage: a table of single-cycle vectors
// followed by hand-written stall, redirect and reset sequences.
module tb_exm;
  import exm_pkg::*;

  // Clock / reset
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        input_ready_o, input_valid_i;
  logic [31:0] pc_i, alu_operand1_i, alu_operand2_i;
  logic [2:0]  alu_op_i, branch_cond_i;
  logic        alu_sub_i, alu_shift_left_i, alu_signed_shift_i;
  logic [19:0] branch_offset_i;
  logic        reg_write_i, ls_enable_i, ls_write_i, ls_unsigned_load_i;
  logic [4:0]  reg_addr_i;
  logic [31:0] ls_write_data_i;
  logic [3:0]  ls_sel_i;
  logic        output_ready_i, output_valid_o;
  logic [31:0] result_o, ls_write_data_o, branch_target_o;
  logic        reg_write_o, ls_enable_o, ls_write_o, ls_unsigned_load_o, branch_o;
  logic [4:0]  reg_addr_o;
  logic [3:0]  ls_sel_o;

  exm #(.RESET_PC(32'h0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .input_ready_o(input_ready_o), .input_valid_i(input_valid_i),
    .pc_i(pc_i), .alu_operand1_i(alu_operand1_i), .alu_operand2_i(alu_operand2_i),
    .alu_op_i(alu_op_i), .alu_sub_i(alu_sub_i), .alu_shift_left_i(alu_shift_left_i),
    .alu_signed_shift_i(alu_signed_shift_i), .branch_cond_i(branch_cond_i),
    .branch_offset_i(branch_offset_i), .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
    .ls_enable_i(ls_enable_i), .ls_write_i(ls_write_i), .ls_write_data_i(ls_write_data_i),
    .ls_sel_i(ls_sel_i), .ls_unsigned_load_i(ls_unsigned_load_i),
    .output_ready_i(output_ready_i), .output_valid_o(output_valid_o), .result_o(result_o),
    .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o), .ls_enable_o(ls_enable_o),
    .ls_write_o(ls_write_o), .ls_write_data_o(ls_write_data_o), .ls_sel_o(ls_sel_o),
    .ls_unsigned_load_o(ls_unsigned_load_o), .branch_o(branch_o),
    .branch_target_o(branch_target_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  alu_op;
    logic        sub;
    logic        sl;
    logic        ss;
    logic [2:0]  cond;
    logic [19:0] off;
    logic        exp_valid;
    logic [31:0] exp_result;
    logic        exp_branch;
    logic [31:0] exp_target;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  int n_vec = 0;
  int n_miss = 0;

  // Scoreboard of results expected out of the stage, oldest first.
  logic [31:0] exp_q[$];

  function automatic vec_t mk(logic [31:0] pc, logic [31:0] op1, logic [31:0] op2,
                              logic [2:0] alu_op, logic sub, logic sl, logic ss,
                              logic [2:0] cond, logic [19:0] off, logic ev,
                              logic [31:0] er, logic eb, logic [31:0] et);
    vec_t v;
    v.pc = pc; v.op1 = op1; v.op2 = op2; v.alu_op = alu_op;
    v.sub = sub; v.sl = sl; v.ss = ss; v.cond = cond; v.off = off;
    v.exp_valid = ev; v.exp_result = er; v.exp_branch = eb; v.exp_target = et;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: present one bundle with pass-through fields derived from tag.
  task automatic drive(input vec_t v, input int tag);
    logic [31:0] t;
    t = tag;
    input_valid_i      = 1'b1;
    pc_i               = v.pc;
    alu_operand1_i     = v.op1;
    alu_operand2_i     = v.op2;
    alu_op_i           = v.alu_op;
    alu_sub_i          = v.sub;
    alu_shift_left_i   = v.sl;
    alu_signed_shift_i = v.ss;
    branch_cond_i      = v.cond;
    branch_offset_i    = v.off;
    reg_write_i        = 1'b1;
    reg_addr_i         = t[4:0];
    ls_enable_i        = t[0];
    ls_write_i         = t[1];
    ls_unsigned_load_i = t[2];
    ls_sel_i           = t[3:0];
    ls_write_data_i    = 32'hA500_0000 | t;
  endtask

  task automatic drive_add(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                           input int tag);
    drive(mk(pc, a, b, ALU_ADD, 0, 0, 0, NO_BRANCH, 20'h0, 0, 0, 0, 0), tag);
  endtask

  initial begin
    vec_t z;
    logic [31:0] t;
    z = mk(0, 0, 0, ALU_ADD, 0, 0, 0, NO_BRANCH, 20'h0, 0, 0, 0, 0);
    drive(z, 0);
    input_valid_i  = 1'b0;
    reg_write_i    = 1'b0;
    output_ready_i = 1'b1;

    //               pc            op1           op2           alu        sub sl ss cond           off       v  result        br target
    vecs[0]  = mk(32'h0000_0000, 32'h7FFF_FFFF, 32'h1,        ALU_ADD,   0, 0, 0, NO_BRANCH,     20'h0,    1, 32'h8000_0000, 0, 32'h0);
    vecs[1]  = mk(32'h0000_0004, 32'd5,        32'd7,        ALU_ADD,   1, 0, 0, NO_BRANCH,     20'h0,    1, 32'hFFFF_FFFE, 0, 32'h0);
    vecs[2]  = mk(32'h0000_0008, 32'h8000_0000, 32'd4,        ALU_SHIFT, 0, 0, 1, NO_BRANCH,     20'h0,    1, 32'hF800_0000, 0, 32'h0);
    vecs[3]  = mk(32'h0000_000C, 32'h8000_0000, 32'd4,        ALU_SHIFT, 0, 0, 0, NO_BRANCH,     20'h0,    1, 32'h0800_0000, 0, 32'h0);
    vecs[4]  = mk(32'h0000_0010, 32'h1,        32'h3F,       ALU_SHIFT, 0, 1, 0, NO_BRANCH,     20'h0,    1, 32'h8000_0000, 0, 32'h0);
    vecs[5]  = mk(32'h0000_0014, 32'hFFFF_FFFF, 32'h1,        ALU_SLT,   0, 0, 0, NO_BRANCH,     20'h0,    1, 32'h1,         0, 32'h0);
    vecs[6]  = mk(32'h0000_0018, 32'hFFFF_FFFF, 32'h1,        ALU_SLTU,  0, 0, 0, NO_BRANCH,     20'h0,    1, 32'h0,         0, 32'h0);
    vecs[7]  = mk(32'h0000_001C, 32'hF0F0_F0F0, 32'hFF00_FF00, ALU_XOR,   0, 0, 0, NO_BRANCH,     20'h0,    1, 32'h0FF0_0FF0, 0, 32'h0);
    vecs[8]  = mk(32'h0000_0020, 32'h0F0,      32'h00F,      ALU_OR,    0, 0, 0, NO_BRANCH,     20'h0,    1, 32'hFF,        0, 32'h0);
    vecs[9]  = mk(32'h0000_0024, 32'hFF00_FF00, 32'hF0F0_F0F0, ALU_AND,   0, 0, 0, NO_BRANCH,     20'h0,    1, 32'hF000_F000, 0, 32'h0);
    vecs[10] = mk(32'h0000_0028, 32'd3,        32'd4,        ALU_ADD,   0, 0, 0, BRANCH_BEQ,    20'h00010, 1, 32'd7,         0, 32'h0);
    vecs[11] = mk(32'h0000_002C, 32'h1,        32'hFFFF_FFFF, ALU_ADD,   0, 0, 0, BRANCH_BGEU,   20'h00010, 1, 32'h0,         0, 32'h0);
    vecs[12] = mk(32'h0000_0100, 32'hFFFF_FFFF, 32'h1,        ALU_ADD,   0, 0, 0, BRANCH_BLT,    20'hFFFF8, 1, 32'h0,         1, 32'hF8);
    vecs[13] = mk(32'h0000_0104, 32'h1,        32'h1,        ALU_ADD,   0, 0, 0, NO_BRANCH,     20'h0,    0, 32'h0,         0, 32'hF8);
    vecs[14] = mk(32'h0000_0108, 32'h1,        32'h1,        ALU_ADD,   0, 0, 0, BRANCH_UNCOND, 20'h0,    0, 32'h0,         0, 32'hF8);
    vecs[15] = mk(32'h0000_00F8, 32'd2,        32'd3,        ALU_ADD,   0, 0, 0, NO_BRANCH,     20'h0,    1, 32'd5,         0, 32'hF8);
    vecs[16] = mk(32'h0000_0040, 32'h2001,     32'h10,       ALU_ADD,   0, 0, 0, BRANCH_UNCOND, 20'h0,    1, 32'h44,        1, 32'h2010);
    vecs[17] = mk(32'h0000_2010, 32'd1,        32'd2,        ALU_ADD,   0, 0, 0, NO_BRANCH,     20'h0,    1, 32'd3,         0, 32'h2010);
    vecs[18] = mk(32'h0000_2014, 32'd1,        32'd2,        ALU_ADD,   0, 0, 0, BRANCH_BNE,    20'h00010, 1, 32'd3,         1, 32'h2024);
    vecs[19] = mk(32'h0000_2024, 32'd5,        32'd5,        ALU_ADD,   0, 0, 0, BRANCH_BGE,    20'hFFFFC, 1, 32'hA,         1, 32'h2020);
    vecs[20] = mk(32'h0000_2028, 32'd1,        32'd1,        ALU_ADD,   0, 0, 0, NO_BRANCH,     20'h0,    0, 32'h0,         0, 32'h2020);
    vecs[21] = mk(32'h0000_2020, 32'd1,        32'd2,        ALU_ADD,   0, 0, 0, BRANCH_BGEU,   20'h00040, 1, 32'd3,         0, 32'h2020);
    vecs[22] = mk(32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd2,        ALU_ADD,   0, 0, 0, BRANCH_UNCOND, 20'h0,    1, 32'h0,         1, 32'h0);
    vecs[23] = mk(32'h0000_0000, 32'd0,        32'd0,        ALU_ADD,   0, 0, 0, NO_BRANCH,     20'h0,    1, 32'h0,         0, 32'h0);
    vecs[24] = mk(32'hFFFF_FFF0, 32'd9,        32'd9,        ALU_ADD,   0, 0, 0, BRANCH_BEQ,    20'h00020, 1, 32'h12,        1, 32'h10);
    vecs[25] = mk(32'h0000_0010, 32'd4,        32'd4,        ALU_ADD,   0, 0, 0, NO_BRANCH,     20'h0,    1, 32'd8,         0, 32'h10);

    // Reset held for two cycles, released with no input.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("rst_valid", {31'h0, output_valid_o}, 32'h0);
    chk("rst_result", result_o, 32'h0);
    chk("rst_branch", {31'h0, branch_o}, 32'h0);
    chk("rst_target", branch_target_o, 32'h0);
    chk("rst_ls_wdata", ls_write_data_o, 32'h0);
    chk("rst_misc", {20'h0, reg_write_o, reg_addr_o, ls_enable_o, ls_write_o, ls_sel_o,
                     ls_unsigned_load_o}, 32'h0);
    chk("rst_in_ready", {31'h0, input_ready_o}, 32'h1);

    // Table of single-cycle vectors, output always ready.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      drive(vecs[i], i);
      @(posedge clk_i);
      #1;
      t = i;
      chk($sformatf("v%0d_valid", i), {31'h0, output_valid_o}, {31'h0, vecs[i].exp_valid});
      chk($sformatf("v%0d_branch", i), {31'h0, branch_o}, {31'h0, vecs[i].exp_branch});
      chk($sformatf("v%0d_target", i), branch_target_o, vecs[i].exp_target);
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_result", i), result_o, vecs[i].exp_result);
        chk($sformatf("v%0d_pass", i),
            {21'h0, reg_write_o, reg_addr_o, ls_enable_o, ls_write_o, ls_unsigned_load_o, ls_sel_o},
            {21'h0, 1'b1, t[4:0], t[0], t[1], t[2], t[3:0]});
        chk($sformatf("v%0d_wdata", i), ls_write_data_o, 32'hA500_0000 | t);
      end
    end

    // Drain, then stall the output for three cycles with a second bundle waiting.
    @(negedge clk_i);
    input_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("drain_valid", {31'h0, output_valid_o}, 32'h0);

    @(negedge clk_i);
    output_ready_i = 1'b0;
    drive_add(32'h200, 32'd10, 32'd1, 1);
    exp_q.push_back(32'd11);
    @(posedge clk_i);
    #1;
    chk("stall_a_valid", {31'h0, output_valid_o}, 32'h1);
    chk("stall_a_result", result_o, exp_q[0]);

    @(negedge clk_i);
    drive_add(32'h204, 32'd20, 32'd2, 2);
    exp_q.push_back(32'd22);
    #1;
    chk("stall_in_ready", {31'h0, input_ready_o}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i);
      #1;
      chk($sformatf("stall%0d_valid", c), {31'h0, output_valid_o}, 32'h1);
      chk($sformatf("stall%0d_result", c), result_o, exp_q[0]);
      chk($sformatf("stall%0d_addr", c), {27'h0, reg_addr_o}, 32'd1);
      chk($sformatf("stall%0d_in_ready", c), {31'h0, input_ready_o}, 32'h0);
    end

    @(negedge clk_i);
    output_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    void'(exp_q.pop_front());
    chk("drain_b_result", result_o, exp_q[0]);
    chk("drain_b_addr", {27'h0, reg_addr_o}, 32'd2);

    @(negedge clk_i);
    drive_add(32'h208, 32'd30, 32'd3, 3);
    exp_q.push_back(32'd33);
    @(posedge clk_i);
    #1;
    void'(exp_q.pop_front());
    chk("drain_c_result", result_o, exp_q[0]);

    @(negedge clk_i);
    input_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    void'(exp_q.pop_front());
    chk("drain_empty_valid", {31'h0, output_valid_o}, 32'h0);
    chk("drain_queue_empty", exp_q.size(), 32'h0);

    // Taken branch while the output then stalls: pulse fires at accept only.
    @(negedge clk_i);
    output_ready_i = 1'b0;
    drive(mk(32'h300, 32'd1, 32'd2, ALU_ADD, 0, 0, 0, BRANCH_BNE, 20'h00040, 0, 0, 0, 0), 4);
    @(posedge clk_i);
    #1;
    chk("stb_branch", {31'h0, branch_o}, 32'h1);
    chk("stb_target", branch_target_o, 32'h340);
    chk("stb_result", result_o, 32'd3);

    @(negedge clk_i);
    drive_add(32'h304, 32'd7, 32'd7, 5);
    #1;
    chk("stb_drop_ready", {31'h0, input_ready_o}, 32'h1);
    @(posedge clk_i);
    #1;
    chk("stb_pulse_end", {31'h0, branch_o}, 32'h0);
    chk("stb_hold_valid", {31'h0, output_valid_o}, 32'h1);
    chk("stb_hold_result", result_o, 32'd3);
    chk("stb_hold_addr", {27'h0, reg_addr_o}, 32'd4);
    chk("stb_hold_target", branch_target_o, 32'h340);

    // Reset while discarding, then a bundle at an unrelated pc must go through.
    @(negedge clk_i);
    input_valid_i = 1'b0;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("rstd_valid", {31'h0, output_valid_o}, 32'h0);
    chk("rstd_target", branch_target_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    output_ready_i = 1'b1;
    drive_add(32'h500, 32'd7, 32'd8, 6);
    @(posedge clk_i);
    #1;
    chk("rstd_after_valid", {31'h0, output_valid_o}, 32'h1);
    chk("rstd_after_result", result_o, 32'hF);
    chk("rstd_after_branch", {31'h0, branch_o}, 32'h0);

    @(negedge clk_i);
    input_valid_i = 1'b0;
    @(posedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
